// File: rtl/cp0_regfile_pkg.sv
// Shared encodings for the CP0 register file: MEM-stage exception types,
// CP0 register numbers, Status/Cause field positions and the exception decoder.
package cp0_regfile_pkg;

  // Exception type encodings carried on except_type_i from MEM.
  localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
  localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
  localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
  localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
  localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
  localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
  localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000a;
  localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000c;
  localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;

  // CP0 register numbers.
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Status field positions.
  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;

  // Cause field positions.
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_HW_LO  = 10;
  localparam int unsigned CAUSE_HW_HI  = 15;
  localparam int unsigned CAUSE_TI     = 30;
  localparam int unsigned CAUSE_BD     = 31;

  // Bits software may change through mtc0.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  typedef enum logic [1:0] {
    ExcNone,
    ExcTake,
    ExcEret
  } exc_kind_e;

  typedef struct packed {
    exc_kind_e  kind;
    logic [4:0] code;
    logic       badvaddr_we;
  } exc_info_t;

  // Map a MEM exception type onto its CP0 action; unknown encodings act as NOEXC.
  function automatic exc_info_t decode_exc(input logic [31:0] exc_type);
    exc_info_t info;
    info.kind        = ExcTake;
    info.code        = 5'h00;
    info.badvaddr_we = 1'b0;
    case (exc_type)
      EXC_TYPE_INT:  info.code = 5'h00;
      EXC_TYPE_ADEL: begin
        info.code        = 5'h04;
        info.badvaddr_we = 1'b1;
      end
      EXC_TYPE_ADES: begin
        info.code        = 5'h05;
        info.badvaddr_we = 1'b1;
      end
      EXC_TYPE_SYS:  info.code = 5'h08;
      EXC_TYPE_BP:   info.code = 5'h09;
      EXC_TYPE_RI:   info.code = 5'h0a;
      EXC_TYPE_OV:   info.code = 5'h0c;
      EXC_TYPE_ERET: info.kind = ExcEret;
      default:       info.kind = ExcNone;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: divided free-running Count, Compare register and a sticky
// timer interrupt that only a Compare write can clear.
module cp0_timer
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        phase_q, phase_d;
  logic        timer_int_q, timer_int_d;

  // Next-state for Count, divider phase, Compare and the interrupt flag.
  always_comb begin
    count_d     = count_q;
    phase_d     = phase_q;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;

    if (count_we) begin
      // A software write restarts the divider so the new value holds a full period.
      count_d = wdata;
      phase_d = 1'b0;
    end else if (COUNT_DIV == 1) begin
      count_d = count_q + 32'd1;
    end else begin
      phase_d = ~phase_q;
      if (phase_q) begin
        count_d = count_q + 32'd1;
      end
    end

    if (compare_we) begin
      compare_d = wdata;
    end

    if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_int_d = 1'b1;
    end
    // Clearing on a Compare write beats a coincident match.
    if (compare_we) begin
      timer_int_d = 1'b0;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      phase_q     <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      phase_q     <= phase_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count     = count_q;
  assign compare   = compare_q;
  assign timer_int = timer_int_q;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: mtc0/mfc0 access, exception capture from MEM
// (Status, Cause, EPC, BadVAddr) and the Count/Compare timer.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int unsigned COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [31:0] except_type_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] badvaddr_i,
  input  logic [5:0]  ext_int_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  exc_info_t exc;
  logic      mtc0_en;
  logic      timer_int;
  logic [31:0] count;
  logic [31:0] compare;

  assign exc = decode_exc(except_type_i);

  // An instruction being flushed by an exception or ERET must not commit its mtc0.
  assign mtc0_en = we_i && (exc.kind == ExcNone);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0_en && (waddr_i == CP0_COUNT)),
    .compare_we (mtc0_en && (waddr_i == CP0_COMPARE)),
    .wdata      (data_i),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  // Next-state for Status, Cause, EPC and BadVAddr.
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (mtc0_en) begin
      case (waddr_i)
        CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
        CP0_CAUSE:  cause_d  = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        CP0_EPC:    epc_d    = data_i;
        default:    ;
      endcase
    end

    // Hardware-owned Cause fields track the interrupt lines every cycle.
    cause_d[CAUSE_HW_HI:CAUSE_HW_LO] = {ext_int_i[5] | timer_int, ext_int_i[4:0]};
    cause_d[CAUSE_TI]                = timer_int;

    unique case (exc.kind)
      ExcTake: begin
        // Nested exceptions keep the original return point.
        if (!status_q[STATUS_EXL]) begin
          epc_d             = is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
          cause_d[CAUSE_BD] = is_in_delayslot_i;
        end
        status_d[STATUS_EXL]               = 1'b1;
        cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc.code;
        if (exc.badvaddr_we) begin
          badvaddr_d = badvaddr_i;
        end
      end
      ExcEret: status_d[STATUS_EXL] = 1'b0;
      default: ;
    endcase
  end

  // Architectural CP0 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // mfc0 read mux; unmapped numbers read as zero.
  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      CP0_BADVADDR: data_o = badvaddr_q;
      CP0_COUNT:    data_o = count;
      CP0_COMPARE:  data_o = compare;
      CP0_STATUS:   data_o = status_q;
      CP0_CAUSE:    data_o = cause_q;
      CP0_EPC:      data_o = epc_q;
      default:      data_o = 32'd0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign count_o     = count;
  assign compare_o   = compare;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: stimulus queues hand-computed expectations
// tagged with the cycle they apply to; a negedge monitor pops and compares them.
module tb_cp0_regfile;

  localparam int S_STATUS   = 0;
  localparam int S_CAUSE    = 1;
  localparam int S_EPC      = 2;
  localparam int S_COUNT    = 3;
  localparam int S_COMPARE  = 4;
  localparam int S_BADVADDR = 5;
  localparam int S_TIMER    = 6;
  localparam int S_DATA     = 7;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [31:0] except_type_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] badvaddr_i;
  logic [5:0]  ext_int_i;
  logic [31:0] data_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] badvaddr_o;
  logic        timer_int_o;

  cp0_regfile #(
    .STATUS_RST (32'h0040_0000),
    .COUNT_DIV  (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .we_i              (we_i),
    .waddr_i           (waddr_i),
    .raddr_i           (raddr_i),
    .data_i            (data_i),
    .except_type_i     (except_type_i),
    .pc_i              (pc_i),
    .is_in_delayslot_i (is_in_delayslot_i),
    .badvaddr_i        (badvaddr_i),
    .ext_int_i         (ext_int_i),
    .data_o            (data_o),
    .status_o          (status_o),
    .cause_o           (cause_o),
    .epc_o             (epc_o),
    .count_o           (count_o),
    .compare_o         (compare_o),
    .badvaddr_o        (badvaddr_o),
    .timer_int_o       (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues.
  int          q_cyc[$];
  int          q_sel[$];
  logic [31:0] q_val[$];
  string       q_name[$];
  int          total = 0;
  int          bad = 0;
  logic        done = 1'b0;

  function automatic logic [31:0] pick(input int s);
    case (s)
      S_STATUS:   return status_o;
      S_CAUSE:    return cause_o;
      S_EPC:      return epc_o;
      S_COUNT:    return count_o;
      S_COMPARE:  return compare_o;
      S_BADVADDR: return badvaddr_o;
      S_TIMER:    return {31'd0, timer_int_o};
      default:    return data_o;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; flush leftovers once done.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && (q_cyc[0] <= cyc || done)) begin
      int          c;
      int          s;
      logic [31:0] v;
      logic [31:0] a;
      string       n;
      c = q_cyc.pop_front();
      s = q_sel.pop_front();
      v = q_val.pop_front();
      n = q_name.pop_front();
      a = pick(s);
      total++;
      if (c != cyc) begin
        bad++;
        $display("FAIL %s: check for cycle %0d not serviced (now %0d)", n, c, cyc);
      end else if (a !== v) begin
        bad++;
        $display("FAIL %s: got %08h expected %08h (cycle %0d)", n, a, v, cyc);
      end
    end
  end

  task automatic exp(input int sel, input logic [31:0] v, input string n);
    q_cyc.push_back(cyc);
    q_sel.push_back(sel);
    q_val.push_back(v);
    q_name.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i              = 1'b0;
    waddr_i           = 5'd0;
    data_i            = 32'd0;
    except_type_i     = 32'd0;
    pc_i              = 32'd0;
    is_in_delayslot_i = 1'b0;
    badvaddr_i        = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i    = 1'b1;
    waddr_i = a;
    data_i  = d;
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                     input logic [31:0] bv);
    except_type_i     = t;
    pc_i              = pc;
    is_in_delayslot_i = ds;
    badvaddr_i        = bv;
  endtask

  initial begin
    rst       = 1'b1;
    ext_int_i = 6'd0;
    raddr_i   = 5'd12;
    idle();
    repeat (3) tick();
    rst = 1'b0;

    // Reset state.
    exp(S_STATUS, 32'h0040_0000, "rst_status");
    exp(S_CAUSE, 32'd0, "rst_cause");
    exp(S_EPC, 32'd0, "rst_epc");
    exp(S_COUNT, 32'd0, "rst_count");
    exp(S_COMPARE, 32'd0, "rst_compare");
    exp(S_BADVADDR, 32'd0, "rst_badvaddr");
    exp(S_TIMER, 32'd0, "rst_timer");
    exp(S_DATA, 32'h0040_0000, "rst_mfc0_status");

    // Compare=5, then Count=0 to pin the divider phase.
    mtc0(5'd11, 32'd5);
    tick();
    mtc0(5'd9, 32'd0);
    tick();
    idle();
    raddr_i = 5'd11;
    exp(S_COUNT, 32'd0, "cnt_after_write");
    exp(S_DATA, 32'd5, "mfc0_compare");
    repeat (10) tick();
    raddr_i = 5'd9;
    exp(S_COUNT, 32'd5, "cnt_reach5");
    exp(S_DATA, 32'd5, "mfc0_count");
    exp(S_TIMER, 32'd0, "timer_not_yet");
    tick();
    exp(S_TIMER, 32'd1, "timer_set");
    exp(S_COUNT, 32'd5, "cnt_hold5");
    tick();
    exp(S_CAUSE, 32'h4000_8000, "cause_ti_ip7");
    exp(S_COUNT, 32'd6, "cnt_6");
    exp(S_TIMER, 32'd1, "timer_sticky");
    mtc0(5'd11, 32'd0);
    tick();
    idle();
    exp(S_TIMER, 32'd0, "timer_cleared");
    exp(S_COMPARE, 32'd0, "compare_zero");
    exp(S_CAUSE, 32'h4000_8000, "cause_lag");
    tick();
    exp(S_CAUSE, 32'd0, "cause_ti_clear");
    exp(S_COUNT, 32'd7, "cnt_7");

    // ADEL in a delay slot.
    exc(32'h04, 32'hbfc0_0100, 1'b1, 32'h1);
    tick();
    idle();
    raddr_i = 5'd14;
    exp(S_EPC, 32'hbfc0_00fc, "adel_epc");
    exp(S_CAUSE, 32'h8000_0010, "adel_cause");
    exp(S_BADVADDR, 32'h1, "adel_badvaddr");
    exp(S_STATUS, 32'h0040_0002, "adel_status");
    exp(S_DATA, 32'hbfc0_00fc, "mfc0_epc");

    // Nested OV: EPC/BD hold, ExcCode updates, BadVAddr untouched.
    exc(32'h0c, 32'h80, 1'b0, 32'hdead);
    tick();
    idle();
    exp(S_EPC, 32'hbfc0_00fc, "ov_epc_hold");
    exp(S_CAUSE, 32'h8000_0030, "ov_cause");
    exp(S_BADVADDR, 32'h1, "ov_badvaddr_hold");

    // ERET.
    exc(32'h0e, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    exp(S_STATUS, 32'h0040_0000, "eret_status");
    exp(S_EPC, 32'hbfc0_00fc, "eret_epc");
    exp(S_CAUSE, 32'h8000_0030, "eret_cause");

    // mtc0 Status squashed by a same-cycle SYS.
    mtc0(5'd12, 32'h0000_ff01);
    exc(32'h08, 32'h100, 1'b0, 32'h0);
    tick();
    idle();
    exp(S_STATUS, 32'h0040_0002, "sys_status");
    exp(S_CAUSE, 32'h0000_0020, "sys_cause");
    exp(S_EPC, 32'h100, "sys_epc");
    exc(32'h0e, 32'h0, 1'b0, 32'h0);
    tick();
    idle();

    // Write masks.
    mtc0(5'd12, 32'hffff_ffff);
    tick();
    idle();
    exp(S_STATUS, 32'h0040_ff03, "status_mask");
    mtc0(5'd12, 32'd0);
    tick();
    mtc0(5'd13, 32'hffff_ffff);
    tick();
    idle();
    exp(S_STATUS, 32'h0040_0000, "status_clear");
    exp(S_CAUSE, 32'h0000_0320, "cause_mask");

    // Undefined exception type acts as NOEXC, so the mtc0 commits.
    mtc0(5'd14, 32'hdead_beef);
    exc(32'h03, 32'h200, 1'b1, 32'h0);
    tick();
    idle();
    exp(S_EPC, 32'hdead_beef, "undef_epc");
    exp(S_CAUSE, 32'h0000_0320, "undef_cause");

    // Count wrap.
    mtc0(5'd9, 32'hffff_ffff);
    tick();
    idle();
    exp(S_COUNT, 32'hffff_ffff, "cnt_max");
    tick();
    exp(S_COUNT, 32'hffff_ffff, "cnt_max_hold");
    tick();
    exp(S_COUNT, 32'd0, "cnt_wrap");

    // BadVAddr read-only, external interrupts, unmapped read.
    mtc0(5'd8, 32'h1234);
    ext_int_i = 6'b100101;
    tick();
    idle();
    raddr_i = 5'd3;
    exp(S_BADVADDR, 32'h1, "badvaddr_ro");
    exp(S_CAUSE, 32'h0000_9720, "cause_ext_int");
    exp(S_DATA, 32'd0, "mfc0_unmapped");
    tick();
    raddr_i = 5'd8;
    ext_int_i = 6'd0;
    exp(S_DATA, 32'h1, "mfc0_badvaddr");
    tick();
    done = 1'b1;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file for the PipelineMIPS core; the consuming end of the MEM-stage exception path.
- Captures the exception type, faulting PC and bad address produced in MEM, and updates Status, Cause, EPC and BadVAddr accordingly.
- Also services mtc0/mfc0 and runs the Count/Compare timer.
- Feeds cp0_status, cp0_cause and cp0_epc back to exception detection, and the timer interrupt to the interrupt line.

Parameters:
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).
- COUNT_DIV, 2, Count increments once every COUNT_DIV clock cycles. Legal values: 1 or 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- we_i  in  1  mtc0 write enable
- waddr_i  in  5  mtc0 destination register number
- raddr_i  in  5  mfc0 source register number
- data_i  in  32  mtc0 write data
- except_type_i  in  32  exception type from MEM; `EXC_TYPE_* encodings
- pc_i  in  32  PC of the MEM instruction
- is_in_delayslot_i  in  1  MEM instruction sits in a branch delay slot
- badvaddr_i  in  32  faulting address from MEM
- ext_int_i  in  6  hardware interrupt lines
- data_o  out  32  mfc0 read data, combinational
- status_o  out  32  Status register
- cause_o  out  32  Cause register
- epc_o  out  32  EPC register
- count_o  out  32  Count register
- compare_o  out  32  Compare register
- badvaddr_o  out  32  BadVAddr register
- timer_int_o  out  1  timer interrupt pending

Behaviour:
- Reset (async, rst=1):
  - Status=STATUS_RST.
  - Cause, EPC, Count, Compare, BadVAddr = 0.
  - timer_int_o=0, divider phase=0.
  - data_o follows registers, so it reads 0 except Status.
- Register map: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14. Any other address reads 0 and ignores writes.
- All updates occur at the posedge. Effects are visible on outputs the following cycle. No same-cycle write-to-read bypass.
- Writable fields:
  - Status: bits [15:8] (IM), [1] (EXL), [0] (IE). Other bits hold their reset value.
  - Cause: bits [9:8] (soft IP) only.
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr: read-only.
- Cause hardware fields, every cycle:
  - Cause[15:10] <= {ext_int_i[5] | timer_int, ext_int_i[4:0]}.
  - Cause[30] (TI) <= timer_int.
- Count:
  - Increments by 1 every COUNT_DIV cycles and wraps 32'hFFFF_FFFF -> 0.
  - An mtc0 to Count overrides the increment in that cycle and resets the divider phase.
- Timer:
  - timer_int_o sets when Compare!=0 and Count==Compare. It stays set until an mtc0 to Compare.
  - A Compare write clears timer_int_o even if the match condition holds in the same cycle. Set/clear conflict: the clear wins.
- Exception (except_type_i not NOEXC and not ERET):
  - If Status.EXL==0: EPC <= is_in_delayslot_i ? pc_i-4 : pc_i; Cause[31] (BD) <= is_in_delayslot_i.
  - If Status.EXL==1: EPC and BD hold.
  - Always: Status.EXL <= 1; Cause[6:2] <= ExcCode.
  - ExcCode mapping: INT=0x00, ADEL=0x04, ADES=0x05, SYS=0x08, BP=0x09, RI=0x0a, OV=0x0c.
  - For ADEL/ADES only: BadVAddr <= badvaddr_i.
- ERET: Status.EXL <= 0. No other field changes.
- Same-cycle mtc0 plus exception/ERET: the mtc0 is discarded entirely, because the instruction is being flushed. The exception update, Count increment, timer and Cause hardware-field updates all proceed.
- Undefined except_type_i encodings are treated as NOEXC.

Decomposition:
- defines.vh holds:
  - EXC_TYPE_INT=32'h01, ADEL=32'h04, ADES=32'h05, SYS=32'h08, BP=32'h09, RI=32'h0a, OV=32'h0c, ERET=32'h0e, NOEXC=32'h00.
  - CP0 register numbers: CP0_BADVADDR, CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC.
  - Status/Cause field bit positions.
- One natural sub-module: cp0_timer (Count, divider, Compare, timer_int). The rest stays flat.

Test Plan:
- Reset -> status_o=32'h0040_0000; all other outputs 0; mfc0 addr 12 returns 32'h0040_0000.
- mtc0 Compare=5, COUNT_DIV=2 -> Count reaches 5 after 10 cycles; timer_int_o=1 and cause_o[15]=1, [30]=1 the next cycle; mtc0 Compare=0 -> timer_int_o=0 the following cycle.
- Exception ADEL, pc_i=32'hbfc0_0100, delayslot=1, badvaddr_i=32'h1 -> EPC=32'hbfc0_00fc, Cause[31]=1, Cause[6:2]=4, BadVAddr=1, EXL=1.
- Second exception OV while EXL=1, pc_i=32'h80 -> EPC unchanged, Cause[6:2]=0x0c; then ERET -> EXL=0, EPC unchanged.
- Same cycle: mtc0 Status=32'h0000_ff01 plus SYS exception -> Status bits [15:8] and IE unchanged, EXL=1, ExcCode=8.
- mtc0 Count=32'hFFFF_FFFF -> wraps to 0 after COUNT_DIV cycles; write to addr 8 -> BadVAddr unchanged; read of addr 3 -> 0.
